pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/branch_resolve.sv | 46 ++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the PC sequencer slice.
//   XLEN     : datapath width (32).
//   br_op_e  : 3-bit branch/jump op codes presented by the EX stage.
//   seq_st_e : sequencer FSM states; StTrap exists only when MISALIGN_TRAP_EN is defined.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BGE  = 3'b011,
    BR_JAL  = 3'b100,
    BR_JALR = 3'b101,
    BR_RSVD = 3'b110,
    BR_NONE = 3'b111
  } br_op_e;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StFlush, StTrap} seq_st_e;
`else
  typedef enum logic [1:0] {StBoot, StRun, StFlush} seq_st_e;
`endif

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: EX-stage branch inputs, fetch handshake and sequencer outputs.
//   slave  : the sequencer side (consumes EX/fetch inputs, drives PC and control).
//   master : the pipeline side (drives EX/fetch inputs, observes PC and control).
interface pc_sequencer_if;
  import rv32_pkg::*;

  logic            stall_i;
  logic            br_valid_i;
  logic [2:0]      branch_i;
  logic            zero_flag_i;
  logic            less_flag_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] rs1_i;
  logic            fetch_ready_i;
  logic [XLEN-1:0] pc_o;
  logic            fetch_valid_o;
  logic            flush_o;
  logic            taken_o;
  logic [XLEN-1:0] link_o;
  logic            trap_o;

  modport slave (
    input  stall_i, br_valid_i, branch_i, zero_flag_i, less_flag_i,
    input  ex_pc_i, imm_i, rs1_i, fetch_ready_i,
    output pc_o, fetch_valid_o, flush_o, taken_o, link_o, trap_o
  );

  modport master (
    output stall_i, br_valid_i, branch_i, zero_flag_i, less_flag_i,
    output ex_pc_i, imm_i, rs1_i, fetch_ready_i,
    input  pc_o, fetch_valid_o, flush_o, taken_o, link_o, trap_o
  );

endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: purely combinational branch decision and target computation.
//   branch_i          : op code (rv32_pkg::br_op_e encoding)
//   zero_flag_i       : ALU equality flag
//   less_flag_i       : ALU less-than flag
//   ex_pc_i/imm_i/rs1_i : EX-stage PC, sign-extended offset, rs1 value
//   taken_o           : op redirects the PC (br_valid qualification is done by the caller)
//   target_o          : raw redirect target; JALR has bit 0 cleared, no further alignment
module branch_resolve
  import rv32_pkg::*;
(
  input  logic [2:0]      branch_i,
  input  logic            zero_flag_i,
  input  logic            less_flag_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o
);

  localparam logic [XLEN-1:0] ClrBit0 = {{(XLEN-1){1'b1}}, 1'b0};

  br_op_e          w_op;
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_reg_rel;

  assign w_op      = br_op_e'(branch_i);
  assign w_pc_rel  = ex_pc_i + imm_i;
  assign w_reg_rel = (rs1_i + imm_i) & ClrBit0;

  always_comb begin
    taken_o = 1'b0;
    case (w_op)
      BR_BEQ:  taken_o = zero_flag_i;
      BR_BNE:  taken_o = ~zero_flag_i;
      BR_BLT:  taken_o = less_flag_i;
      BR_BGE:  taken_o = ~less_flag_i;
      BR_JAL:  taken_o = 1'b1;
      BR_JALR: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

  assign target_o = (w_op == BR_JALR) ? w_reg_rel : w_pc_rel;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with branch redirect and post-redirect flush window.
//   clk, rst     : clock; synchronous active-high reset (priority over everything)
//   bus (slave)  : EX-stage branch inputs, fetch handshake, pc/flush/taken/link/trap outputs
// Parameters:
//   RESET_VECTOR : PC loaded on reset
//   FLUSH_CYCLES : flush_o cycles after a redirect, legal 1..7
// Build option: MISALIGN_TRAP_EN -- a taken target with bits[1:0]!=0 enters a sticky trap
// state; when undefined, targets are forced word-aligned and trap_o is tied 0.
module pc_sequencer
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  pc_sequencer_if.slave     bus
);

  localparam int unsigned     CntW     = 3;
  localparam logic [CntW-1:0] CntLoad  = CntW'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] WordMask = {{(XLEN-2){1'b1}}, 2'b00};

  seq_st_e         r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic            w_br_taken;
  logic [XLEN-1:0] w_target;
  logic            w_fetch_valid;
  logic            w_flush;
  logic            w_taken;
  logic            w_trap;

  branch_resolve u_branch_resolve (
    .branch_i    (bus.branch_i),
    .zero_flag_i (bus.zero_flag_i),
    .less_flag_i (bus.less_flag_i),
    .ex_pc_i     (bus.ex_pc_i),
    .imm_i       (bus.imm_i),
    .rs1_i       (bus.rs1_i),
    .taken_o     (w_br_taken),
    .target_o    (w_target)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cnt_nxt     = r_cnt;
    w_fetch_valid = 1'b0;
    w_flush       = 1'b0;
    w_taken       = 1'b0;
    w_trap        = 1'b0;
    case (r_state)
      StBoot: begin
        w_flush     = 1'b1;
        w_state_nxt = StRun;
      end
      StRun: begin
        w_fetch_valid = 1'b1;
        // A redirect wins over stall and fetch backpressure.
        if (bus.br_valid_i && w_br_taken) begin
          w_taken = 1'b1;
`ifdef MISALIGN_TRAP_EN
          w_pc_nxt = w_target;
          if (w_target[1:0] != 2'b00) begin
            w_state_nxt = StTrap;
          end else begin
            w_state_nxt = StFlush;
            w_cnt_nxt   = CntLoad;
          end
`else
          w_pc_nxt    = w_target & WordMask;
          w_state_nxt = StFlush;
          w_cnt_nxt   = CntLoad;
`endif
        end else if (bus.fetch_ready_i && !bus.stall_i) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      StFlush: begin
        w_flush = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = StRun;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`ifdef MISALIGN_TRAP_EN
      StTrap: begin
        // Sticky until reset.
        w_flush = 1'b1;
        w_trap  = 1'b1;
      end
`endif
      default: begin
        w_flush     = 1'b1;
        w_state_nxt = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_VECTOR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.fetch_valid_o = w_fetch_valid;
  assign bus.flush_o       = w_flush;
  assign bus.taken_o       = w_taken;
  assign bus.trap_o        = w_trap;
  assign bus.link_o        = bus.ex_pc_i + 32'd4;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. Directed scenarios plus a randomized
// run against a cycle-level reference model (counts of remaining flush cycles, boot/trap flags).
// Honours MISALIGN_TRAP_EN for its expectations.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int unsigned FC = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_trap;
  int          m_flush_left;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_taken(input logic [2:0] op, input logic z, input logic l);
    case (op)
      3'd0:    return z;
      3'd1:    return !z;
      3'd2:    return l;
      3'd3:    return !l;
      3'd4:    return 1'b1;
      3'd5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    if (op == 3'd5) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = pc + imm;
    end
    return t;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs, then step time.
  task automatic tick();
    logic        tk;
    logic [31:0] tg;
    tk = ref_taken(bus.branch_i, bus.zero_flag_i, bus.less_flag_i);
    tg = ref_target(bus.branch_i, bus.ex_pc_i, bus.imm_i, bus.rs1_i);
    if (rst) begin
      m_pc = RV; m_boot = 1'b1; m_trap = 1'b0; m_flush_left = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      m_trap = 1'b1;
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (bus.br_valid_i && tk) begin
`ifdef MISALIGN_TRAP_EN
      m_pc = tg;
      if (tg[1:0] != 2'b00) m_trap = 1'b1;
      else m_flush_left = FC;
`else
      tg[1:0] = 2'b00;
      m_pc = tg;
      m_flush_left = FC;
`endif
    end else if (bus.fetch_ready_i && !bus.stall_i) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_i = 1'b0; bus.br_valid_i = 1'b0; bus.branch_i = 3'b111;
    bus.zero_flag_i = 1'b0; bus.less_flag_i = 1'b0;
    bus.ex_pc_i = 32'h0; bus.imm_i = 32'h0; bus.rs1_i = 32'h0;
    bus.fetch_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    idle_inputs();
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b100; // reset must override a JAL
    tick();
    tick();
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (bus.pc_o !== RV) begin
      bad++; $display("FAIL reset_pc got=%h want=%h", bus.pc_o, RV);
    end
    total++;
    if (obs !== 4'b0100) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", obs, 4'b0100);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    logic [3:0]  obs;
    logic [3:0]  want;
    bus.fetch_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs  = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
      want = (i == 0) ? 4'b0100 : 4'b1000;
      total++;
      if (bus.pc_o !== exp_pc[i]) begin
        bad++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, bus.pc_o, exp_pc[i]);
      end
      total++;
      if (obs !== want) begin
        bad++; $display("FAIL seq_ctl[%0d] got=%b want=%b", i, obs, want);
      end
      tick();
    end
  endtask

  task automatic test_beq_stall();
    logic [3:0] obs;
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b000; bus.zero_flag_i = 1'b1;
    bus.ex_pc_i = 32'h100; bus.imm_i = 32'h20; bus.stall_i = 1'b1; bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (obs !== 4'b1010) begin
      bad++; $display("FAIL beq_decide got=%b want=%b", obs, 4'b1010);
    end
    tick();
    idle_inputs();
    bus.fetch_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
      total++;
      if (bus.pc_o !== 32'h120) begin
        bad++; $display("FAIL beq_pc[%0d] got=%h want=%h", k, bus.pc_o, 32'h120);
      end
      total++;
      if (obs !== ((k < 2) ? 4'b0100 : 4'b1000)) begin
        bad++; $display("FAIL beq_ctl[%0d] got=%b want=%b", k, obs, (k < 2) ? 4'b0100 : 4'b1000);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (bus.pc_o !== 32'h124) begin
      bad++; $display("FAIL beq_resume got=%h want=%h", bus.pc_o, 32'h124);
    end
    tick();
  endtask

  task automatic test_jalr();
    logic [3:0] obs;
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b101; bus.ex_pc_i = 32'h300; bus.imm_i = 32'h0;
`ifdef MISALIGN_TRAP_EN
    bus.rs1_i = 32'h206;
`else
    bus.rs1_i = 32'h203;
`endif
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (obs !== 4'b1010) begin
      bad++; $display("FAIL jalr_decide got=%b want=%b", obs, 4'b1010);
    end
    total++;
    if (bus.link_o !== 32'h304) begin
      bad++; $display("FAIL jalr_link got=%h want=%h", bus.link_o, 32'h304);
    end
    tick();
    idle_inputs();
    bus.fetch_ready_i = 1'b1;
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      bus.br_valid_i = 1'b1; bus.branch_i = 3'b100; // ignored while trapped
      @(negedge clk);
      obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
      total++;
      if (bus.pc_o !== 32'h206) begin
        bad++; $display("FAIL trap_pc[%0d] got=%h want=%h", k, bus.pc_o, 32'h206);
      end
      total++;
      if (obs !== 4'b0101) begin
        bad++; $display("FAIL trap_ctl[%0d] got=%b want=%b", k, obs, 4'b0101);
      end
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (bus.pc_o !== RV || obs !== 4'b0100) begin
      bad++; $display("FAIL trap_reset got=%h/%b want=%h/%b", bus.pc_o, obs, RV, 4'b0100);
    end
    tick();
`else
    @(negedge clk);
    total++;
    if (bus.pc_o !== 32'h200) begin
      bad++; $display("FAIL jalr_pc got=%h want=%h", bus.pc_o, 32'h200);
    end
    tick();
    tick();
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b101; bus.rs1_i = 32'h206;
    tick();
    idle_inputs();
    bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.pc_o !== 32'h204) begin
      bad++; $display("FAIL jalr_align got=%h want=%h", bus.pc_o, 32'h204);
    end
    total++;
    if (bus.trap_o !== 1'b0) begin
      bad++; $display("FAIL jalr_notrap got=%b want=%b", bus.trap_o, 1'b0);
    end
    tick();
    tick();
`endif
  endtask

  task automatic test_bne_backpressure();
    logic [31:0] hold_pc;
    logic [3:0]  obs;
    hold_pc = m_pc;
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b001; bus.zero_flag_i = 1'b1;
    bus.fetch_ready_i = 1'b0; bus.stall_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
      total++;
      if (bus.pc_o !== hold_pc) begin
        bad++; $display("FAIL bne_pc[%0d] got=%h want=%h", k, bus.pc_o, hold_pc);
      end
      total++;
      if (obs !== 4'b1000) begin
        bad++; $display("FAIL bne_ctl[%0d] got=%b want=%b", k, obs, 4'b1000);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_wrap_and_flush_reset();
    logic [3:0] obs;
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b100;
    bus.ex_pc_i = 32'hFFFF_FFF0; bus.imm_i = 32'h0000_000C;
    tick();
    idle_inputs();
    bus.fetch_ready_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (bus.pc_o !== 32'hFFFF_FFFC || bus.fetch_valid_o !== 1'b1) begin
      bad++; $display("FAIL wrap_pre got=%h/%b want=%h/1", bus.pc_o, bus.fetch_valid_o,
                      32'hFFFF_FFFC);
    end
    tick();
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (bus.pc_o !== 32'h0 || obs !== 4'b1000) begin
      bad++; $display("FAIL wrap_post got=%h/%b want=%h/%b", bus.pc_o, obs, 32'h0, 4'b1000);
    end
    bus.br_valid_i = 1'b1; bus.branch_i = 3'b100; bus.ex_pc_i = 32'h40; bus.imm_i = 32'h40;
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.flush_o !== 1'b1 || bus.pc_o !== 32'h80) begin
      bad++; $display("FAIL midflush got=%b/%h want=1/%h", bus.flush_o, bus.pc_o, 32'h80);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
    total++;
    if (bus.pc_o !== RV || obs !== 4'b0100) begin
      bad++; $display("FAIL flush_reset got=%h/%b want=%h/%b", bus.pc_o, obs, RV, 4'b0100);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  obs;
    logic [3:0]  want;
    logic        run;
    logic [31:0] imm;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.stall_i       = ($urandom_range(0, 3) == 0);
      bus.br_valid_i    = ($urandom_range(0, 2) == 0);
      bus.branch_i      = 3'($urandom_range(0, 7));
      bus.zero_flag_i   = 1'($urandom_range(0, 1));
      bus.less_flag_i   = 1'($urandom_range(0, 1));
      bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
      bus.ex_pc_i       = $urandom & 32'hFFFF_FFFC;
      bus.rs1_i         = $urandom;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      bus.imm_i = imm;
      @(negedge clk);
      run  = !m_boot && !m_trap && (m_flush_left == 0);
      want = {run, !run, run && bus.br_valid_i &&
              ref_taken(bus.branch_i, bus.zero_flag_i, bus.less_flag_i), m_trap};
      obs  = {bus.fetch_valid_o, bus.flush_o, bus.taken_o, bus.trap_o};
      total++;
      if (bus.pc_o !== m_pc) begin
        bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", n, bus.pc_o, m_pc);
      end
      total++;
      if (obs !== want) begin
        bad++; $display("FAIL rnd_ctl[%0d] got=%b want=%b", n, obs, want);
      end
      total++;
      if (bus.link_o !== bus.ex_pc_i + 32'd4) begin
        bad++; $display("FAIL rnd_link[%0d] got=%h want=%h", n, bus.link_o, bus.ex_pc_i + 32'd4);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_pc = RV; m_boot = 1'b1; m_trap = 1'b0; m_flush_left = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_beq_stall();
    test_jalr();
    test_bne_backpressure();
    test_wrap_and_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
